pulse_stretch: RTL and testbench

Converts single-cycle event pulses, such as the output of the edge detector on button and note-trigger paths, into level pulses held high for a fixed number of cycles. Events that arrive while an output pulse is active are queued in a saturating pending counter and replayed as separate stretched pulses, with a guaranteed low gap between them. It sits between pulse-producing control logic and slow consumers such as LEDs, display strobes and codec enables.

---
 rtl/pulse_stretch_pkg.sv | 10 +
 rtl/pulse_stretch_if.sv | 10 +
 rtl/pulse_stretch_load_down_counter.sv | 16 +
 rtl/pulse_stretch.sv | 91 +++++++++
 tb/tb_pulse_stretch.sv | 64 ++++++
 5 files changed

// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared state encoding, default timing constants and counter sizing helper.
package pulse_stretch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;
   localparam int HOLD_CYCLES_DEF = 4;
   localparam int GAP_CYCLES_DEF = 2;
   localparam int PEND_W_DEF = 2;
   function automatic int cnt_w(input int h, input int g);
      return $clog2((h > g ? h : g) + 1);
   endfunction
endpackage

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: event input and stretched-pulse status bundle.
interface pulse_stretch_if #(parameter int PEND_W = 2);
   logic in;
   logic out;
   logic busy;
   logic overflow;
   logic [PEND_W-1:0] pending;
   modport master (output in, input out, busy, pending, overflow);
   modport slave (input in, output out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretch_load_down_counter.sv
// load_down_counter: loadable down counter; done flags the final count of a loaded run.
module load_down_counter #(parameter int W = 3) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign done = cnt_q == W'(1);
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches single-cycle events into fixed-length pulses with queued replay.
// Define PULSE_STRETCH_RETRIGGER_EN to make events during HOLD extend the pulse instead of queueing.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
   parameter int PEND_W      = PEND_W_DEF
) (
   input logic clk,
   input logic reset,
   pulse_stretch_if.slave bus
);
   localparam int CW = cnt_w(HOLD_CYCLES, GAP_CYCLES);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   state_t state_q, state_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic out_q, out_d, busy_q, busy_d, overflow_q, overflow_d;
   logic hold_load, hold_done, gap_load, gap_done;
   logic arrive, consume, retrig, direct;
   always_comb begin
      state_d   = state_q;
      hold_load = 1'b0;
      gap_load  = 1'b0;
      consume   = 1'b0;
      retrig    = 1'b0;
      direct    = 1'b0;
      case (state_q)
         IDLE: if (bus.in) begin
            state_d   = HOLD;
            hold_load = 1'b1;
         end
         HOLD:
`ifdef PULSE_STRETCH_RETRIGGER_EN
            if (bus.in) begin
               hold_load = 1'b1;
               retrig    = 1'b1;
            end else
`endif
            if (hold_done) begin
               state_d  = GAP;
               gap_load = 1'b1;
            end
         GAP: if (gap_done) begin
            // Queued events take priority; a fresh event is only taken directly when the queue is empty.
            if (pending_q != '0) begin
               state_d   = HOLD;
               hold_load = 1'b1;
               consume   = 1'b1;
            end else if (bus.in) begin
               state_d   = HOLD;
               hold_load = 1'b1;
               direct    = 1'b1;
            end else state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      arrive     = bus.in && state_q != IDLE && !retrig && !direct;
      overflow_d = arrive && !consume && pending_q == PEND_MAX;
      pending_d  = (arrive && !consume && !overflow_d) ? pending_q + PEND_W'(1) :
                   (consume && !arrive) ? pending_q - PEND_W'(1) : pending_q;
      out_d      = state_d == HOLD;
      busy_d     = state_d != IDLE;
   end
   always_ff @(posedge clk)
      if (reset) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         out_q      <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   load_down_counter #(.W(CW)) u_hold (
      .clk(clk), .rst(reset), .load(hold_load), .load_val(CW'(HOLD_CYCLES)),
      .en(state_q == HOLD), .done(hold_done)
   );
   load_down_counter #(.W(CW)) u_gap (
      .clk(clk), .rst(reset), .load(gap_load), .load_val(CW'(GAP_CYCLES)),
      .en(state_q == GAP), .done(gap_done)
   );
   assign bus.out      = out_q;
   assign bus.busy     = busy_q;
   assign bus.pending  = pending_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: directed cycle-by-cycle checks of pulse_stretch with HOLD=4, GAP=2, PEND_W=2.
module tb_pulse_stretch;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   pulse_stretch_if #(.PEND_W(2)) bus();
   pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] rng(input int a, input int b);
      logic [63:0] m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction
   task automatic chk(input string tag, input int c, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %0d expected %0d", tag, c, got, exp);
      end
   endtask
   // Cycle c starts at the c-th rising edge; outputs are sampled 1ns after it, inputs driven for that cycle.
   task automatic run(input string name, input int n, input logic [63:0] in_m, input logic [63:0] rst_m,
                      input logic [63:0] out_m, input logic [63:0] busy_m, input logic [63:0] p0_m,
                      input logic [63:0] p1_m, input logic [63:0] ovf_m);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         if (c > 0) begin
            chk({name, " out"}, c, {1'b0, bus.out}, {1'b0, out_m[c]});
            chk({name, " busy"}, c, {1'b0, bus.busy}, {1'b0, busy_m[c]});
            chk({name, " pending"}, c, bus.pending, {p1_m[c], p0_m[c]});
            chk({name, " overflow"}, c, {1'b0, bus.overflow}, {1'b0, ovf_m[c]});
         end
         bus.in = in_m[c];
         reset  = rst_m[c];
      end
   endtask
   initial begin
      bus.in = 1'b0;
      run("single", 20, rng(10, 10), rng(0, 2), rng(11, 14), rng(11, 16), '0, '0, '0);
      run("gap_end", 26, rng(10, 10) | rng(16, 16), rng(0, 2),
          rng(11, 14) | rng(17, 20), rng(11, 22), '0, '0, '0);
      run("reset_mid", 24, rng(10, 10) | rng(12, 12) | rng(14, 14), rng(0, 2) | rng(12, 12),
          rng(11, 12) | rng(15, 18), rng(11, 12) | rng(15, 20), '0, '0, '0);
`ifdef PULSE_STRETCH_RETRIGGER_EN
      run("retrig", 24, rng(10, 10) | rng(13, 13), rng(0, 2), rng(11, 17), rng(11, 19), '0, '0, '0);
`else
      run("queue", 26, rng(10, 10) | rng(12, 12), rng(0, 2),
          rng(11, 14) | rng(17, 20), rng(11, 22), rng(13, 16), '0, '0);
      run("hold_evt", 24, rng(10, 10) | rng(13, 13), rng(0, 2),
          rng(11, 14) | rng(17, 20), rng(11, 22), rng(14, 16), '0, '0);
      run("overflow", 38, rng(10, 14), rng(0, 2),
          rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32), rng(11, 34),
          rng(12, 12) | rng(14, 16) | rng(23, 28), rng(13, 22), rng(15, 15));
      run("swap", 32, rng(10, 10) | rng(12, 12) | rng(16, 16), rng(0, 2),
          rng(11, 14) | rng(17, 20) | rng(23, 26), rng(11, 28), rng(13, 22), '0, '0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
